// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for the up/down counter: drives load/enable/direction
// so the counter runs lo -> hi -> lo for a programmed number of sweeps.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0]   count,
    output logic               cnt_en,
    output logic               cnt_up_down,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweeps_done
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StUp   = 3'd2;
    localparam logic [2:0] StDown = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [SWEEP_W-1:0] n_q, n_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic               err_q, err_d;

    logic [SWEEP_W:0]   sweeps_inc;
    logic               last_sweep;
    logic               at_peak;
    logic               at_floor;
    logic               run_active;

    assign sweeps_inc = {1'b0, sweeps_q} + {{SWEEP_W{1'b0}}, 1'b1};
    assign last_sweep = (sweeps_inc == {1'b0, n_q});

    // Magnitude compares keep the counter from wrapping even if count is disturbed.
    assign at_peak    = (count >= hi_q);
    assign at_floor   = (count <= lo_q);
    assign run_active = (state_q == StLoad) || (state_q == StUp) || (state_q == StDown);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        n_d      = n_q;
        sweeps_d = sweeps_q;
        err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if ((lo < hi) && (n_sweeps != '0)) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        n_d      = n_sweeps;
                        sweeps_d = '0;
                        state_d  = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                state_d = abort ? StIdle : StUp;
            end
            StUp: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (at_peak) begin
                    state_d = StDown;
                end
            end
            StDown: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (at_floor) begin
                    if (!(&sweeps_q)) begin
                        sweeps_d = sweeps_inc[SWEEP_W-1:0];
                    end
                    state_d = last_sweep ? StDone : StUp;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            n_q      <= '0;
            sweeps_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            n_q      <= n_d;
            sweeps_q <= sweeps_d;
            err_q    <= err_d;
        end
    end

    // Strobes are gated by abort in the same cycle so the counter never moves on an abort.
    always_comb begin
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b0;
        case (state_q)
            StLoad: begin
                cnt_load    = !abort;
                cnt_up_down = 1'b1;
            end
            StUp: begin
                cnt_en      = !abort && !at_peak;
                cnt_up_down = 1'b1;
            end
            StDown: begin
                cnt_en      = !abort && !at_floor;
            end
            default: begin
                cnt_en      = 1'b0;
            end
        endcase
    end

    assign cnt_load_val = lo_q;
    assign busy         = run_active;
    assign done         = (state_q == StDone);
    assign err          = err_q;
    assign sweeps_done  = sweeps_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl; a behavioural up/down counter closes the loop.
module tb_updown_sweep_ctrl;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned SWEEP_W = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [WIDTH-1:0]   lo = '0;
    logic [WIDTH-1:0]   hi = '0;
    logic [SWEEP_W-1:0] n_sweeps = '0;
    logic [WIDTH-1:0]   count;
    logic               cnt_en;
    logic               cnt_up_down;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_load_val;
    logic               busy;
    logic               done;
    logic               err;
    logic [SWEEP_W-1:0] sweeps_done;

    int n_checks = 0;
    int n_bad = 0;

    updown_sweep_ctrl #(
        .WIDTH  (WIDTH),
        .SWEEP_W(SWEEP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .lo          (lo),
        .hi          (hi),
        .n_sweeps    (n_sweeps),
        .count       (count),
        .cnt_en      (cnt_en),
        .cnt_up_down (cnt_up_down),
        .cnt_load    (cnt_load),
        .cnt_load_val(cnt_load_val),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sweeps_done (sweeps_done)
    );

    always #5 clk = ~clk;

    // Counter datapath: load beats enable, wraps naturally if mis-driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (cnt_load) begin
            count <= cnt_load_val;
        end else if (cnt_en) begin
            count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and follow it back to IDLE, counting busy cycles, done pulses and count jumps.
    task automatic run_sweep(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h,
                             input logic [SWEEP_W-1:0] n, output int busy_n, output int done_n,
                             output int jumps, output int swept);
        logic [WIDTH-1:0] prev;
        int delta;
        bit finished;
        lo = l;
        hi = h;
        n_sweeps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = 0;
        done_n = 0;
        jumps = 0;
        swept = 0;
        finished = 1'b0;
        prev = count;
        for (int i = 0; i < 400; i++) begin
            delta = (count > prev) ? int'(count - prev) : int'(prev - count);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                swept = int'(sweeps_done);
            end
            if (busy && i >= 2 && delta > 1) jumps++;
            if (count > h || count < l) begin
                if (i >= 1) jumps++;
            end
            prev = count;
            if (i > 0 && !busy && !done) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        if (!finished) check_eq("run_timeout", 32'd0, 32'd1);
    endtask

    logic [WIDTH-1:0] exp_cnt [9] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd5, 4'd4, 4'd3, 4'd3};
    logic             exp_en  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int busy_n, done_n, jumps, swept, dones;
        bit found;

        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_en", cnt_en, 0);
        check_eq("rst_dir", cnt_up_down, 0);
        check_eq("rst_load", cnt_load, 0);
        check_eq("rst_loadval", cnt_load_val, 0);
        check_eq("rst_sweeps", sweeps_done, 0);
        reset = 1'b0;
        tick();

        // Basic run lo=3 hi=6 n=1
        lo = 4'd3;
        hi = 4'd6;
        n_sweeps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b_load", cnt_load, 1);
        check_eq("b_loadval", cnt_load_val, 3);
        check_eq("b_load_en", cnt_en, 0);
        check_eq("b_load_dir", cnt_up_down, 1);
        check_eq("b_load_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq($sformatf("b_cnt%0d", i), count, exp_cnt[i]);
            if (i < 8) check_eq($sformatf("b_en%0d", i), cnt_en, exp_en[i]);
            check_eq($sformatf("b_busy%0d", i), busy, (i < 8) ? 1 : 0);
            check_eq($sformatf("b_done%0d", i), done, (i == 8) ? 1 : 0);
        end
        check_eq("b_sweeps", sweeps_done, 1);
        tick();
        check_eq("b_idle_done", done, 0);

        // Rejected starts
        lo = 4'd5;
        hi = 4'd5;
        n_sweeps = 8'd3;
        start = 1'b1;
        #1;
        check_eq("r1_load_now", cnt_load, 0);
        tick();
        start = 1'b0;
        check_eq("r1_err", err, 1);
        check_eq("r1_busy", busy, 0);
        check_eq("r1_load", cnt_load, 0);
        tick();
        check_eq("r1_err_off", err, 0);
        check_eq("r1_latched", cnt_load_val, 3);
        lo = 4'd2;
        hi = 4'd9;
        n_sweeps = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("r2_err", err, 1);
        check_eq("r2_busy", busy, 0);
        check_eq("r2_load", cnt_load, 0);
        tick();
        check_eq("r2_err_off", err, 0);
        check_eq("r2_latched", cnt_load_val, 3);
        check_eq("r2_sweeps", sweeps_done, 1);

        // Full range, two sweeps
        run_sweep(4'd0, 4'd15, 8'd2, busy_n, done_n, jumps, swept);
        check_eq("f_busy", busy_n, 65);
        check_eq("f_done", done_n, 1);
        check_eq("f_nowrap", jumps, 0);
        check_eq("f_sweeps", swept, 2);

        // Abort in DOWN at count=4 on sweep 2 of 3
        lo = 4'd2;
        hi = 4'd6;
        n_sweeps = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy && !cnt_up_down && sweeps_done == 8'd1 && count == 4'd4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("a_found", found, 1);
        abort = 1'b1;
        #1;
        check_eq("a_en", cnt_en, 0);
        check_eq("a_load", cnt_load, 0);
        tick();
        abort = 1'b0;
        check_eq("a_idle", busy, 0);
        check_eq("a_cnt_hold", count, 4);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            tick();
        end
        check_eq("a_nodone", dones, 0);
        check_eq("a_sweeps", sweeps_done, 1);

        // Start held high through the run and the DONE cycle is ignored
        lo = 4'd1;
        hi = 4'd3;
        n_sweeps = 8'd1;
        start = 1'b1;
        tick();
        lo = 4'd0;
        hi = 4'd15;
        n_sweeps = 8'd5;
        busy_n = 0;
        dones = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                dones++;
                check_eq("s_loadval", cnt_load_val, 1);
                check_eq("s_sweeps", sweeps_done, 1);
            end
            if (!busy && !done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        check_eq("s_back_idle", found, 1);
        check_eq("s_busy", busy_n, 7);
        check_eq("s_dones", dones, 1);
        check_eq("s_max", count, 1);
        tick();
        check_eq("s_no_restart", busy, 0);
        lo = 4'd1;
        hi = 4'd3;
        n_sweeps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("s_fresh_clr", sweeps_done, 0);
        check_eq("s_fresh_load", cnt_load, 1);
        for (int i = 0; i < 20; i++) tick();

        // Asynchronous reset mid-UP
        lo = 4'd2;
        hi = 4'd10;
        n_sweeps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("x_up_dir", cnt_up_down, 1);
        check_eq("x_up_en", cnt_en, 1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("x_busy", busy, 0);
        check_eq("x_en", cnt_en, 0);
        check_eq("x_dir", cnt_up_down, 0);
        check_eq("x_loadval", cnt_load_val, 0);
        check_eq("x_sweeps", sweeps_done, 0);
        check_eq("x_done", done, 0);
        #2;
        reset = 1'b0;
        tick();
        run_sweep(4'd1, 4'd2, 8'd1, busy_n, done_n, jumps, swept);
        check_eq("x2_busy", busy_n, 5);
        check_eq("x2_done", done_n, 1);
        check_eq("x2_sweeps", swept, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives the team's up/down counter through programmed triangle sweeps: lo → hi → lo, repeated N times.
- Owns the counter's control inputs: enable, direction and load. Observes the counter's count output to find turning points.
- Sits between the config/test-control logic (start/abort) and the counter datapath. Reports busy, done and error status.

Parameters:
- WIDTH, 4, counter width; width of lo, hi, count and cnt_load_val.
- SWEEP_W, 8, width of the sweep-count request and the progress counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  terminate the current run.
- lo  input  WIDTH  lower sweep bound; latched when start is accepted.
- hi  input  WIDTH  upper sweep bound; latched when start is accepted.
- n_sweeps  input  SWEEP_W  number of full sweeps; latched when start is accepted.
- count  input  WIDTH  current counter value.
- cnt_en  output  1  counter step enable.
- cnt_up_down  output  1  counter direction; 1 = up, 0 = down.
- cnt_load  output  1  synchronous load strobe to the counter.
- cnt_load_val  output  WIDTH  load value; equals latched lo.
- busy  output  1  high in LOAD, UP and DOWN.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse when a start is rejected.
- sweeps_done  output  SWEEP_W  number of completed sweeps.

Behaviour:
- Counter contract:
  - cnt_load has priority over cnt_en.
  - count reflects load or step on the edge after the strobe.
  - Counter has no own enable gating beyond cnt_en.
- Reset (asynchronous): state = IDLE; latched lo/hi/n = 0; sweeps_done = 0; all outputs 0.
- States are IDLE, LOAD, UP, DOWN, DONE. All outputs are decoded from state, count and abort.
- IDLE:
  - All strobes are 0.
  - start = 1 with lo < hi and n_sweeps != 0: latch lo/hi/n, clear sweeps_done, go to LOAD.
  - start = 1 with lo >= hi or n_sweeps == 0: err = 1 on the next cycle for one cycle, remain IDLE, latched values unchanged.
- LOAD: one cycle. cnt_load = 1, cnt_up_down = 1, cnt_en = 0. Go to UP.
- UP:
  - cnt_up_down = 1; cnt_en = (count < hi_q).
  - When count >= hi_q, cnt_en = 0 (one dwell cycle at the peak), then go to DOWN.
- DOWN:
  - cnt_up_down = 0; cnt_en = (count > lo_q).
  - When count <= lo_q, cnt_en = 0 (dwell), sweeps_done increments.
  - Then go to DONE if sweeps_done + 1 == n_q, else go to UP.
- DONE: done = 1, busy = 0, all strobes 0. Go to IDLE next cycle.
- Magnitude compares (not equality) guarantee no counter wrap, even if count is perturbed out of range.
- Run length: busy for exactly 1 + n*(2*(hi - lo) + 2) cycles. done follows immediately after.
- abort in LOAD/UP/DOWN:
  - Same cycle: cnt_en and cnt_load are forced to 0.
  - Next edge: state = IDLE.
  - No done pulse; sweeps_done holds its value.
  - abort in IDLE or DONE has no effect.
- start while not in IDLE (including DONE) is ignored. No queuing.
- Simultaneous start and abort in IDLE: start wins (abort has no effect in IDLE).
- sweeps_done saturates at 2^SWEEP_W - 1. It cannot be reached in practice, since n_q bounds it.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, no done pulse.

Test Plan:
- Basic run (WIDTH = 4): start pulse with lo = 3, hi = 6, n = 1.
  - LOAD in cycle 1 with cnt_load_val = 3.
  - count runs 3, 4, 5, 6, 6, 5, 4, 3, 3.
  - cnt_en is 0 on both dwell cycles.
  - busy is high for 9 cycles; done pulses in cycle 10; sweeps_done = 1.
- Full range: lo = 0, hi = 15, n = 2.
  - count never wraps past 15 or below 0.
  - busy is high for 65 cycles; sweeps_done = 2 at done.
- Rejects:
  - lo = 5, hi = 5, n = 3: err pulses once, busy stays 0, no cnt_load.
  - lo = 2, hi = 9, n = 0: same result.
- Abort: abort asserted in DOWN at count = 4 on sweep 2 of 3.
  - cnt_en = 0 in the abort cycle; IDLE next cycle.
  - done never asserts; sweeps_done stays 1.
- Start while busy, including in the DONE cycle: start is ignored.
  - Latched bounds are unchanged; exactly one done pulse.
  - A fresh start after IDLE clears sweeps_done to 0.
- Asynchronous reset mid-UP, between clock edges: all outputs go to 0 immediately.
  - A following start with lo = 1, hi = 2, n = 1 completes in 5 busy cycles.
